// File: rtl/decode_cycle_if.sv
// ---------------------------------------------------------------------------
// decode_cycle_if
//
// Purpose: bundles every non-clock, non-reset signal of the decode stage.
// These are the Fetch-stage inputs, the writeback port, the stall/flush
// controls and the registered ID/EX outputs.
//
// Modports:
//   master - the surrounding pipeline. It drives the Fetch, writeback and
//            stall/flush signals and observes the *E outputs.
//   slave  - the decode stage itself (decode_cycle).
//
// Signal summary:
//   o_p_waitrequest     stall, 1 = hold everything
//   FlushE              squash the decoded controls at the next edge
//   InstrD/PCD/PCPlus4D Fetch-stage outputs
//   RegWriteW/RDW/ResultW  register-file writeback port
//   RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE
//                       registered controls
//   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E
//                       registered data
//   RS1_E, RS2_E, RD_E  registered register indices
// ---------------------------------------------------------------------------
interface decode_cycle_if #(
   parameter int ALU_CTRL_W = 3
);
   logic                  o_p_waitrequest;
   logic                  FlushE;
   logic [31:0]           InstrD;
   logic [31:0]           PCD;
   logic [31:0]           PCPlus4D;
   logic                  RegWriteW;
   logic [4:0]            RDW;
   logic [31:0]           ResultW;

   logic                  RegWriteE;
   logic                  ALUSrcE;
   logic                  MemWriteE;
   logic                  ResultSrcE;
   logic                  BranchE;
   logic [ALU_CTRL_W-1:0] ALUControlE;
   logic [31:0]           RD1_E;
   logic [31:0]           RD2_E;
   logic [31:0]           Imm_Ext_E;
   logic [31:0]           PCE;
   logic [31:0]           PCPlus4E;
   logic [4:0]            RS1_E;
   logic [4:0]            RS2_E;
   logic [4:0]            RD_E;

   modport master (
      output o_p_waitrequest, FlushE, InstrD, PCD, PCPlus4D,
             RegWriteW, RDW, ResultW,
      input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E
   );

   modport slave (
      input  o_p_waitrequest, FlushE, InstrD, PCD, PCPlus4D,
             RegWriteW, RDW, ResultW,
      output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
             RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RS1_E, RS2_E, RD_E
   );
endinterface

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
//
// Purpose: RISC-V style decode stage. It holds a 32x32 register file, an
// opcode/funct decoder and an immediate generator, and registers the result
// into the ID/EX pipeline register.
//
// Ports:
//   clk  - single clock, all state changes on posedge
//   rst  - asynchronous, active-low reset. It clears the ID/EX register and
//          the whole register file.
//   bus  - decode_cycle_if.slave. It carries the Fetch inputs, the writeback
//          port, stall/flush and all registered *E outputs.
//
// Configuration macro: DECODE_RF_BYPASS_EN
//   defined   - a read that hits the register being written this cycle
//               returns ResultW directly.
//   undefined - such a read returns the value stored before the write.
// ---------------------------------------------------------------------------
module decode_cycle #(
   parameter int ALU_CTRL_W = 3
) (
   input logic          clk,
   input logic          rst,
   decode_cycle_if.slave bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b000);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b001);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b010);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b011);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b101);

   typedef struct packed {
      logic                  regWrite;
      logic                  aluSrc;
      logic                  memWrite;
      logic                  resultSrc;
      logic                  branch;
      logic [ALU_CTRL_W-1:0] aluControl;
      logic [31:0]           rd1;
      logic [31:0]           rd2;
      logic [31:0]           immExt;
      logic [31:0]           pc;
      logic [31:0]           pcPlus4;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
   } idEx_t;

   logic [31:0] rf_q [32];
   idEx_t       idEx_q;
   idEx_t       idEx_d;
   idEx_t       decoded;
   logic [31:0] rd1Val;
   logic [31:0] rd2Val;
   logic [31:0] immI;
   logic [31:0] immS;
   logic [31:0] immB;

   wire  [31:0] instr = bus.InstrD;
   wire  [4:0]  rs1   = instr[19:15];
   wire  [4:0]  rs2   = instr[24:20];

   // Maps funct3 onto the ALU operation. The subtract request is only
   // honoured for funct3=000. I-ALU callers always pass 0 here, so their
   // funct3=000 stays add.
   function automatic logic [ALU_CTRL_W-1:0] aluFromFunct(input logic [2:0] funct3,
                                                        input logic       subReq);
      case (funct3)
         3'b000:  aluFromFunct = subReq ? ALU_SUB : ALU_ADD;
         3'b010:  aluFromFunct = ALU_SLT;
         3'b110:  aluFromFunct = ALU_OR;
         3'b111:  aluFromFunct = ALU_AND;
         default: aluFromFunct = ALU_ADD;
      endcase
   endfunction

   // Register file: x0 is never written, so it reads back the reset zero.
   // Writes are suppressed while the pipeline is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (bus.RegWriteW && !bus.o_p_waitrequest && (bus.RDW != 5'd0)) begin
         rf_q[bus.RDW] <= bus.ResultW;
      end
   end

   // Combinational read ports. The optional bypass forwards the writeback
   // data when the read address matches the register being written.
   always_comb begin
      rd1Val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
      rd2Val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
`ifdef DECODE_RF_BYPASS_EN
      if (bus.RegWriteW && (bus.RDW != 5'd0) && (bus.RDW == rs1)) rd1Val = bus.ResultW;
      if (bus.RegWriteW && (bus.RDW != 5'd0) && (bus.RDW == rs2)) rd2Val = bus.ResultW;
`endif
   end

   // Immediate candidates, all sign-extended from instr[31].
   always_comb begin
      immI = {{20{instr[31]}}, instr[31:20]};
      immS = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      immB = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   end

   // Main decoder. Unknown opcodes, including the all-zero Fetch bubble,
   // fall through with every control at 0 and a zero immediate.
   always_comb begin
      decoded         = '0;
      decoded.rd1     = rd1Val;
      decoded.rd2     = rd2Val;
      decoded.pc      = bus.PCD;
      decoded.pcPlus4 = bus.PCPlus4D;
      decoded.rs1     = rs1;
      decoded.rs2     = rs2;
      decoded.rd      = instr[11:7];
      case (instr[6:0])
         OP_LOAD: begin
            decoded.regWrite   = 1'b1;
            decoded.aluSrc     = 1'b1;
            decoded.resultSrc  = 1'b1;
            decoded.aluControl = ALU_ADD;
            decoded.immExt     = immI;
         end
         OP_STORE: begin
            decoded.memWrite   = 1'b1;
            decoded.aluSrc     = 1'b1;
            decoded.aluControl = ALU_ADD;
            decoded.immExt     = immS;
         end
         OP_RTYPE: begin
            decoded.regWrite   = 1'b1;
            decoded.aluControl = aluFromFunct(instr[14:12], instr[30]);
         end
         OP_IALU: begin
            decoded.regWrite   = 1'b1;
            decoded.aluSrc     = 1'b1;
            decoded.aluControl = aluFromFunct(instr[14:12], 1'b0);
            decoded.immExt     = immI;
         end
         OP_BRANCH: begin
            decoded.branch     = 1'b1;
            decoded.aluControl = ALU_SUB;
            decoded.immExt     = immB;
         end
         default: ;
      endcase
   end

   // ID/EX next state. A flush wins over a stall: data still loads, but the
   // controls are forced to a bubble. A stall without a flush holds.
   always_comb begin
      idEx_d = idEx_q;
      if (bus.FlushE) begin
         idEx_d            = decoded;
         idEx_d.regWrite   = 1'b0;
         idEx_d.aluSrc     = 1'b0;
         idEx_d.memWrite   = 1'b0;
         idEx_d.resultSrc  = 1'b0;
         idEx_d.branch     = 1'b0;
         idEx_d.aluControl = '0;
      end else if (!bus.o_p_waitrequest) begin
         idEx_d = decoded;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) idEx_q <= '0;
      else      idEx_q <= idEx_d;
   end

   assign bus.RegWriteE   = idEx_q.regWrite;
   assign bus.ALUSrcE     = idEx_q.aluSrc;
   assign bus.MemWriteE   = idEx_q.memWrite;
   assign bus.ResultSrcE  = idEx_q.resultSrc;
   assign bus.BranchE     = idEx_q.branch;
   assign bus.ALUControlE = idEx_q.aluControl;
   assign bus.RD1_E       = idEx_q.rd1;
   assign bus.RD2_E       = idEx_q.rd2;
   assign bus.Imm_Ext_E   = idEx_q.immExt;
   assign bus.PCE         = idEx_q.pc;
   assign bus.PCPlus4E    = idEx_q.pcPlus4;
   assign bus.RS1_E       = idEx_q.rs1;
   assign bus.RS2_E       = idEx_q.rs2;
   assign bus.RD_E        = idEx_q.rd;

endmodule
